// File: rtl/wb_pipe_reg.sv
// ----------------------------------------------------------------------------
// wb_pipe_reg
//   Memory -> write-back pipeline stage with a valid/ready handshake.
//   It carries NUM_CH independent write-back channels per entry and holds up
//   to two entries: a main register that drives the outputs and a skid
//   register for the second entry. Back-pressure never drops or duplicates a
//   result, and entries leave in the order they arrived.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   flush      : synchronous discard of all held entries
//   in_valid   : memory stage presents an entry
//   in_ready   : stage can accept an entry this cycle
//   in_we      : per-channel write enable            [NUM_CH]
//   in_waddr   : per-channel destination address    [NUM_CH*ADDR_W]
//   in_data    : per-channel result                 [NUM_CH*DATA_W]
//   out_valid  : entry presented to write-back
//   out_ready  : write-back consumes the entry this cycle
//   out_we     : per-channel write enable, 0 while out_valid=0
//   out_waddr  : destination addresses of the output entry
//   out_data   : results of the output entry
//   occupancy  : number of entries held (0..2)
// ----------------------------------------------------------------------------
module wb_pipe_reg #(
   parameter int unsigned NUM_CH    = 1,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ZERO_SUPP = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_CH-1:0]          in_we,
   input  logic [NUM_CH*ADDR_W-1:0]   in_waddr,
   input  logic [NUM_CH*DATA_W-1:0]   in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_CH-1:0]          out_we,
   output logic [NUM_CH*ADDR_W-1:0]   out_waddr,
   output logic [NUM_CH*DATA_W-1:0]   out_data,
   output logic [1:0]                 occupancy
);

   // State encoding equals the number of held entries.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;

   logic [NUM_CH-1:0]          r_main_we;
   logic [NUM_CH*ADDR_W-1:0]   r_main_waddr;
   logic [NUM_CH*DATA_W-1:0]   r_main_data;
   logic [NUM_CH-1:0]          r_skid_we;
   logic [NUM_CH*ADDR_W-1:0]   r_skid_waddr;
   logic [NUM_CH*DATA_W-1:0]   r_skid_data;

   logic [NUM_CH-1:0]          w_cap_we;
   logic                       w_in_fire;
   logic                       w_out_fire;
   logic                       w_load_main_in;
   logic                       w_load_main_skid;
   logic                       w_load_skid_in;

   // Handshake signals come straight from the state register, so there is
   // no combinational path from any input to any output.
   assign in_ready   = (r_state != S_FULL);
   assign out_valid  = (r_state != S_EMPTY);
   assign occupancy  = r_state;
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;

   // Register 0 is hard-wired to zero: drop its write enable at capture so
   // the register file never sees a write to it.
   always_comb begin
      w_cap_we = in_we;
      if (ZERO_SUPP != 0) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_cap_we[i] = in_we[i] & (in_waddr[i*ADDR_W +: ADDR_W] != '0);
         end
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid_in   = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_in_fire) begin
               w_state_nxt    = S_ONE;
               w_load_main_in = 1'b1;
            end
         end
         S_ONE: begin
            if (w_in_fire && w_out_fire) begin
               w_load_main_in = 1'b1;
            end else if (w_in_fire) begin
               w_state_nxt    = S_FULL;
               w_load_skid_in = 1'b1;
            end else if (w_out_fire) begin
               w_state_nxt    = S_EMPTY;
            end
         end
         S_FULL: begin
            // The skid entry is older than anything upstream, so it moves
            // to main before any new input is taken.
            if (w_out_fire) begin
               w_state_nxt      = S_ONE;
               w_load_main_skid = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_EMPTY;
         end
      endcase
      // Flush overrides everything, including an input offered this cycle.
      if (flush) begin
         w_state_nxt      = S_EMPTY;
         w_load_main_in   = 1'b0;
         w_load_main_skid = 1'b0;
         w_load_skid_in   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main_we    <= '0;
         r_main_waddr <= '0;
         r_main_data  <= '0;
      end else if (w_load_main_in) begin
         r_main_we    <= w_cap_we;
         r_main_waddr <= in_waddr;
         r_main_data  <= in_data;
      end else if (w_load_main_skid) begin
         r_main_we    <= r_skid_we;
         r_main_waddr <= r_skid_waddr;
         r_main_data  <= r_skid_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_skid_we    <= '0;
         r_skid_waddr <= '0;
         r_skid_data  <= '0;
      end else if (w_load_skid_in) begin
         r_skid_we    <= w_cap_we;
         r_skid_waddr <= in_waddr;
         r_skid_data  <= in_data;
      end
   end

   // Data flops are not cleared on flush; gating we with valid is enough.
   assign out_we    = r_main_we & {NUM_CH{out_valid}};
   assign out_waddr = r_main_waddr;
   assign out_data  = r_main_data;

endmodule
